id_token_scanner: RTL and testbench

- Parametrised successor to the single-bit identifier recogniser.
- Scans a valid-qualified character stream for identifier tokens: one or more letters, then one or more digits, with letter/digit runs allowed to alternate.
- Reports a live match flag, the current token length, a completion pulse, a saturating match counter and a sticky overflow flag.
- Sits after the character source in the lexer datapath; its outputs feed token-statistics logic.

---
 rtl/id_pkg.sv | 30 +++
 rtl/id_token_scanner_if.sv | 28 ++
 rtl/id_char_class.sv | 36 +++
 rtl/id_token_scanner.sv | 105 ++++++++++
 tb/tb_id_token_scanner.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// Shared lexer definitions: scanner state encodings, character class codes
// and the ASCII bounds used by the character classifier.
package id_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALPHA = 2'd1,
      ST_DIGIT = 2'd2,
      ST_SKIP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_SEP    = 2'd0,
      CLS_LETTER = 2'd1,
      CLS_DIGIT  = 2'd2
   } cls_t;

   localparam logic [7:0] ASC_UPPER_A = 8'h41;
   localparam logic [7:0] ASC_UPPER_Z = 8'h5A;
   localparam logic [7:0] ASC_LOWER_A = 8'h61;
   localparam logic [7:0] ASC_LOWER_Z = 8'h7A;
   localparam logic [7:0] ASC_DIGIT_0 = 8'h30;
   localparam logic [7:0] ASC_DIGIT_9 = 8'h39;

   function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/id_token_scanner_if.sv
// Character stream in, token statistics out, between a character source
// (master) and the identifier token scanner (slave).
interface id_token_scanner_if #(
   parameter int CHAR_W  = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic              in_valid;
   logic [CHAR_W-1:0] ch;
   logic              match;
   logic [LEN_W-1:0]  tok_len;
   logic              done;
   logic [CNT_W-1:0]  match_cnt;
   logic              ovf;

   modport master (
      output in_valid, ch,
      input  match, tok_len, done, match_cnt, ovf
   );

   modport slave (
      input  in_valid, ch,
      output match, tok_len, done, match_cnt, ovf
   );

endinterface

// File: rtl/id_char_class.sv
// Combinational character classifier: LETTER, DIGIT or SEP. Any set bit
// above bit 7 forces SEP. CHAR_W must be at least 8.
module id_char_class
   import id_pkg::*;
#(
   parameter int CHAR_W = 8
) (
   input  logic [CHAR_W-1:0] ch,
   output cls_t              cls
);

   logic       upper_set;
   logic [7:0] low;

   generate
      if (CHAR_W > 8) begin : g_wide
         assign upper_set = |ch[CHAR_W-1:8];
      end else begin : g_narrow
         assign upper_set = 1'b0;
      end
   endgenerate

   assign low = ch[7:0];

   always_comb begin
      cls = CLS_SEP;
      if (!upper_set) begin
         if (in_range(low, ASC_UPPER_A, ASC_UPPER_Z) ||
             in_range(low, ASC_LOWER_A, ASC_LOWER_Z))
            cls = CLS_LETTER;
         else if (in_range(low, ASC_DIGIT_0, ASC_DIGIT_9))
            cls = CLS_DIGIT;
      end
   end

endmodule

// File: rtl/id_token_scanner.sv
// Identifier token scanner: letters followed by digits, runs may alternate.
// Optional macro ID_STRICT_START_EN: a token starting with a digit never matches.
module id_token_scanner
   import id_pkg::*;
#(
   parameter int CHAR_W  = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   id_token_scanner_if.slave bus
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   cls_t             cls_p0;
   state_t           state_p1;
   logic             match_p1;
   logic [LEN_W-1:0] len_p1;
   logic             done_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             ovf_p1;
   logic             word_p0;
   logic             at_max_p0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   id_char_class #(.CHAR_W(CHAR_W)) u_class (
      .ch  (bus.ch),
      .cls (cls_p0)
   );

   assign word_p0   = (cls_p0 == CLS_LETTER) || (cls_p0 == CLS_DIGIT);
   assign at_max_p0 = (len_p1 == LEN_MAX);

   // Stage p0 -> p1: classify the accepted character and update the token state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p1 <= ST_IDLE;
         match_p1 <= 1'b0;
         len_p1   <= '0;
         done_p1  <= 1'b0;
         cnt_p1   <= '0;
         ovf_p1   <= 1'b0;
      end else begin
         done_p1 <= 1'b0;
         if (bus.in_valid) begin
            unique case (state_p1)
               ST_IDLE: begin
                  if (cls_p0 == CLS_LETTER) begin
                     state_p1 <= ST_ALPHA;
                     len_p1   <= LEN_W'(1);
                  end
`ifdef ID_STRICT_START_EN
                  else if (cls_p0 == CLS_DIGIT) begin
                     state_p1 <= ST_SKIP;
                  end
`endif
               end
               ST_ALPHA, ST_DIGIT: begin
                  if (word_p0 && at_max_p0) begin
                     // Over-long token: park in SKIP until the next separator
                     state_p1 <= ST_SKIP;
                     match_p1 <= 1'b0;
                     ovf_p1   <= 1'b1;
                  end else if (cls_p0 == CLS_LETTER) begin
                     state_p1 <= ST_ALPHA;
                     match_p1 <= 1'b0;
                     len_p1   <= len_p1 + LEN_W'(1);
                  end else if (cls_p0 == CLS_DIGIT) begin
                     state_p1 <= ST_DIGIT;
                     match_p1 <= 1'b1;
                     len_p1   <= len_p1 + LEN_W'(1);
                  end else begin
                     state_p1 <= ST_IDLE;
                     match_p1 <= 1'b0;
                     len_p1   <= '0;
                     if (state_p1 == ST_DIGIT) begin
                        done_p1 <= 1'b1;
                        cnt_p1  <= sat_inc(cnt_p1);
                     end
                  end
               end
               ST_SKIP: begin
                  if (!word_p0) begin
                     state_p1 <= ST_IDLE;
                     len_p1   <= '0;
                  end
               end
            endcase
         end
      end
   end

   assign bus.match     = match_p1;
   assign bus.tok_len   = len_p1;
   assign bus.done      = done_p1;
   assign bus.match_cnt = cnt_p1;
   assign bus.ovf       = ovf_p1;

endmodule

// File: tb/tb_id_token_scanner.sv
// Directed bench for id_token_scanner: default instance (A) plus a
// CHAR_W=9, MAX_LEN=4, CNT_W=2 instance (B) for length and saturation limits.
module tb_id_token_scanner;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   id_token_scanner_if ba ();
   id_token_scanner_if #(.CHAR_W(9), .MAX_LEN(4), .CNT_W(2)) bb ();

   id_token_scanner dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ba)
   );

   id_token_scanner #(.CHAR_W(9), .MAX_LEN(4), .CNT_W(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      ba.in_valid = 1'b0;
      bb.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_a(input logic [7:0] c);
      ba.in_valid = 1'b1;
      ba.ch = c;
      @(posedge clk);
      #1;
      ba.in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [8:0] c);
      bb.in_valid = 1'b1;
      bb.ch = c;
      @(posedge clk);
      #1;
      bb.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic st_a(input string tag, input logic m, input int len, input logic d);
      chk({tag, ".match"}, ba.match, m);
      chk({tag, ".len"}, ba.tok_len, len);
      chk({tag, ".done"}, ba.done, d);
   endtask

   task automatic st_b(input string tag, input logic m, input int len, input logic d);
      chk({tag, ".match"}, bb.match, m);
      chk({tag, ".len"}, bb.tok_len, len);
      chk({tag, ".done"}, bb.done, d);
   endtask

   initial begin
      reset = 1'b0;
      ba.in_valid = 1'b0; ba.ch = '0;
      bb.in_valid = 1'b0; bb.ch = '0;
      do_reset();
      st_a("rstA", 0, 0, 0);
      chk("rstA.cnt", ba.match_cnt, 0);
      chk("rstA.ovf", ba.ovf, 0);
      st_b("rstB", 0, 0, 0);
      chk("rstB.cnt", bb.match_cnt, 0);
      chk("rstB.ovf", bb.ovf, 0);

      // "ab12 "
      send_a("a"); st_a("ab12.a", 0, 1, 0);
      send_a("b"); st_a("ab12.b", 0, 2, 0);
      send_a("1"); st_a("ab12.1", 1, 3, 0);
      send_a("2"); st_a("ab12.2", 1, 4, 0);
      send_a(" "); st_a("ab12.sp", 0, 0, 1);
      chk("ab12.cnt", ba.match_cnt, 1);
      chk("ab12.ovf", ba.ovf, 0);
      idle(1);     st_a("ab12.after", 0, 0, 0);

      // "a1b2;" then "xyz "
      do_reset();
      send_a("a"); st_a("a1b2.a", 0, 1, 0);
      send_a("1"); st_a("a1b2.1", 1, 2, 0);
      send_a("b"); st_a("a1b2.b", 0, 3, 0);
      send_a("2"); st_a("a1b2.2", 1, 4, 0);
      send_a(";"); st_a("a1b2.semi", 0, 0, 1);
      chk("a1b2.cnt", ba.match_cnt, 1);
      send_a("x"); st_a("xyz.x", 0, 1, 0);
      send_a("y"); st_a("xyz.y", 0, 2, 0);
      send_a("z"); st_a("xyz.z", 0, 3, 0);
      send_a(" "); st_a("xyz.sp", 0, 0, 0);
      chk("xyz.cnt", ba.match_cnt, 1);

      // 'x', three idle cycles, '7', ' '
      do_reset();
      send_a("x"); st_a("gap.x", 0, 1, 0);
      ba.ch = "9";
      idle(3);     st_a("gap.hold", 0, 1, 0);
      send_a("7"); st_a("gap.7", 1, 2, 0);
      send_a(" "); st_a("gap.sp", 0, 0, 1);
      chk("gap.cnt", ba.match_cnt, 1);

      // "9a1 " start-with-digit behaviour
      do_reset();
`ifdef ID_STRICT_START_EN
      send_a("9"); st_a("9a1.9", 0, 0, 0);
      send_a("a"); st_a("9a1.a", 0, 0, 0);
      send_a("1"); st_a("9a1.1", 0, 0, 0);
      send_a(" "); st_a("9a1.sp", 0, 0, 0);
      chk("9a1.cnt", ba.match_cnt, 0);
`else
      send_a("9"); st_a("9a1.9", 0, 0, 0);
      send_a("a"); st_a("9a1.a", 0, 1, 0);
      send_a("1"); st_a("9a1.1", 1, 2, 0);
      send_a(" "); st_a("9a1.sp", 0, 0, 1);
      chk("9a1.cnt", ba.match_cnt, 1);
`endif

      // MAX_LEN=4: "abcd5 e1 ", then exactly-max "abc1 "
      do_reset();
      send_b("a"); send_b("b"); send_b("c");
      send_b("d"); st_b("max.d", 0, 4, 0);
      chk("max.d.ovf", bb.ovf, 0);
      send_b("5"); st_b("max.5", 0, 4, 0);
      chk("max.5.ovf", bb.ovf, 1);
      send_b("6"); st_b("max.skip", 0, 4, 0);
      send_b(" "); st_b("max.sp", 0, 0, 0);
      chk("max.sp.cnt", bb.match_cnt, 0);
      send_b("e"); st_b("max.e", 0, 1, 0);
      send_b("1"); st_b("max.1", 1, 2, 0);
      send_b(" "); st_b("max.sp2", 0, 0, 1);
      chk("max.sp2.cnt", bb.match_cnt, 1);
      chk("max.sp2.ovf", bb.ovf, 1);
      send_b("a"); send_b("b"); send_b("c");
      send_b("1"); st_b("exact.1", 1, 4, 0);
      send_b(" "); st_b("exact.sp", 0, 0, 1);
      chk("exact.cnt", bb.match_cnt, 2);

      // Upper bit set makes the character a separator
      send_b("a"); send_b("1");
      send_b(9'h161); st_b("wide.sep", 0, 0, 1);
      chk("wide.cnt", bb.match_cnt, 3);

      // CNT_W=2 saturation over five "a1 " tokens
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_b("a"); send_b("1"); send_b(" ");
         chk($sformatf("sat%0d.done", i), bb.done, 1);
         chk($sformatf("sat%0d.cnt", i), bb.match_cnt, (i < 3) ? i + 1 : 3);
      end

      // Reset mid-token, with a separator presented in the same cycle
      send_b("a"); send_b("b");
      send_b("1"); st_b("mid.1", 1, 3, 0);
      bb.in_valid = 1'b1;
      bb.ch = " ";
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bb.in_valid = 1'b0;
      st_b("mid.rst", 0, 0, 0);
      chk("mid.rst.cnt", bb.match_cnt, 0);
      chk("mid.rst.ovf", bb.ovf, 0);
      idle(1);     st_b("mid.after", 0, 0, 0);
      send_b("c"); send_b("2");
      send_b(" "); st_b("mid.c2", 0, 0, 1);
      chk("mid.c2.cnt", bb.match_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
